// File: rtl/prince_sinv_glm_serial_pkg.sv
// Shared definitions for the serial glitch-limited masked PRINCE inverse S-box.
package prince_sinv_glm_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One domain per share-selection vector over the four input bits.
  localparam int NUM_DOMAINS = 16;

  // PRINCE inverse S-box, entry x in bits [4x+3:4x].
  localparam logic [63:0] SINV_TABLE = 64'h1CE5_046A_98DF_237B;

  // Moebius transform: converts a 4-in/4-out truth table into its ANF
  // coefficients, entry m holding the output bits that contain monomial m.
  function automatic logic [63:0] anf_of(input logic [63:0] tbl);
    logic [63:0] f;
    f = tbl;
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 16; m++) begin
        if (((m >> i) & 1) == 1) begin
          f[4*m +: 4] = f[4*m +: 4] ^ f[4*(m ^ (1 << i)) +: 4];
        end
      end
    end
    return f;
  endfunction

  localparam logic [63:0] SINV_ANF = anf_of(SINV_TABLE);

endpackage

// File: rtl/prince_sinv_domain.sv
// Combinational domain function: the share cross-products of every SINV
// monomial whose selection pattern equals d on the monomial's variables.
module prince_sinv_domain
  import prince_sinv_glm_serial_pkg::*;
(
  input  logic [3:0] sel,
  input  logic [3:0] d,
  output logic [3:0] term
);

  // A monomial m contributes here only if d is a subset of m; the product
  // then uses the selected share bits, which are already b on d and a elsewhere.
  // The constant term (monomial 0) lands only in domain 0.
  always_comb begin
    logic [3:0] mask;
    mask = '0;
    term = '0;
    for (int m = 0; m < NUM_DOMAINS; m++) begin
      mask = 4'(m);
      if (((mask & d) == d) && ((mask & sel) == mask)) begin
        term = term ^ SINV_ANF[4*m +: 4];
      end
    end
  end

endmodule

// File: rtl/prince_sinv_glm_serial.sv
// Serial masked PRINCE inverse S-box: one share domain evaluated per cycle,
// results folded into two output shares by domain parity.
module prince_sinv_glm_serial
  import prince_sinv_glm_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_s,
  output logic [3:0] out_t,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [3:0] d_cnt;
  logic [3:0] sh_a, sh_b;
  logic [3:0] acc_s, acc_t;
  logic [3:0] sel;
  logic [3:0] term;

  // Per-bit share multiplexer: bit i comes from b when d[i] is set, else from a.
  assign sel = (sh_b & d_cnt) | (sh_a & ~d_cnt);

  prince_sinv_domain u_domain (
    .sel  (sel),
    .d    (d_cnt),
    .term (term)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (d_cnt == 4'(NUM_DOMAINS - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Share latch, domain counter and parity-steered accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_cnt <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
      acc_s <= '0;
      acc_t <= '0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        sh_a  <= in_a;
        sh_b  <= in_b;
        acc_s <= '0;
        acc_t <= '0;
        d_cnt <= '0;
      end else if (state == ST_RUN) begin
        if (^d_cnt) acc_t <= acc_t ^ term;
        else        acc_s <= acc_s ^ term;
        if (d_cnt != 4'(NUM_DOMAINS - 1)) d_cnt <= d_cnt + 4'd1;
      end
    end
  end

  // Accumulators are only visible while the result is offered.
  assign out_s = out_valid ? acc_s : 4'd0;
  assign out_t = out_valid ? acc_t : 4'd0;

endmodule
